// File: rtl/write_ctl.sv
// write_ctl: parses 3-byte {cmd, adr, dat} records from a byte stream,
// runs one stb/we/ack bus cycle per record and reports the outcome as a
// one-cycle {ack, adr, dat} response record.
module write_ctl #(
   parameter int ACK_TIMEOUT  = 255,
   parameter int BYTE_TIMEOUT = 65535
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] adr_o,
   output logic [7:0] dat_o,
   output logic       stb_o,
   output logic       we_o,
   input  logic       ack_i,
   input  logic [7:0] dat_i,
   output logic       resp_valid,
   output logic       resp_ack,
   output logic [7:0] resp_adr,
   output logic [7:0] resp_dat,
   output logic       err_frame,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_CMD = 2'd0,
      S_ADR = 2'd1,
      S_DAT = 2'd2,
      S_BUS = 2'd3
   } state_t;

   // Terminal counts: a counter value of N-1 marks the Nth counted cycle.
   localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
   localparam logic [15:0] BYTE_LAST = 16'(BYTE_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        we_q, we_d;             // latched cmd bit0
   logic [7:0]  adr_q, adr_d;           // latched address byte
   logic [7:0]  dat_q, dat_d;           // latched data byte
   logic [15:0] wait_q, wait_d;         // stb_o-high cycle counter
   logic [15:0] idle_q, idle_d;         // inter-byte idle counter
   logic [7:0]  adr_o_q, adr_o_d;
   logic [7:0]  dat_o_q, dat_o_d;
   logic        stb_q, stb_d;
   logic        we_o_q, we_o_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_ack_q, resp_ack_d;
   logic [7:0]  resp_adr_q, resp_adr_d;
   logic [7:0]  resp_dat_q, resp_dat_d;
   logic        err_frame_q, err_frame_d;
   logic        overrun_q, overrun_d;
   logic        busy_q, busy_d;

   // Next-state and registered-output computation for the record parser and bus master.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      wait_d       = wait_q;
      idle_d       = idle_q;
      adr_o_d      = adr_o_q;
      dat_o_d      = dat_o_q;
      stb_d        = stb_q;
      we_o_d       = we_o_q;
      resp_valid_d = 1'b0;
      resp_ack_d   = resp_ack_q;
      resp_adr_d   = resp_adr_q;
      resp_dat_d   = resp_dat_q;
      err_frame_d  = 1'b0;
      overrun_d    = 1'b0;

      case (state_q)
         S_CMD: begin
            if (rx_valid) begin
               if (rx_data[7:1] == 7'd0) begin
                  we_d    = rx_data[0];
                  idle_d  = 16'd0;
                  state_d = S_ADR;
               end else begin
                  err_frame_d = 1'b1;
               end
            end else begin
               idle_d = 16'd0;
            end
         end

         S_ADR: begin
            if (rx_valid) begin
               adr_d   = rx_data;
               idle_d  = 16'd0;
               state_d = S_DAT;
            end else if (idle_q == BYTE_LAST) begin
               // Stream went quiet mid-record: drop the partial record.
               err_frame_d = 1'b1;
               idle_d      = 16'd0;
               state_d     = S_CMD;
            end else begin
               idle_d = idle_q + 16'd1;
            end
         end

         S_DAT: begin
            if (rx_valid) begin
               dat_d   = rx_data;
               idle_d  = 16'd0;
               wait_d  = 16'd0;
               stb_d   = 1'b1;
               we_o_d  = we_q;
               adr_o_d = adr_q;
               dat_o_d = rx_data;
               state_d = S_BUS;
            end else if (idle_q == BYTE_LAST) begin
               err_frame_d = 1'b1;
               idle_d      = 16'd0;
               state_d     = S_CMD;
            end else begin
               idle_d = idle_q + 16'd1;
            end
         end

         S_BUS: begin
            // Bytes arriving during the bus cycle are dropped, not queued.
            overrun_d = rx_valid;
            if (ack_i) begin
               // Ack is checked first so it wins over a coincident timeout.
               stb_d        = 1'b0;
               we_o_d       = 1'b0;
               wait_d       = 16'd0;
               resp_valid_d = 1'b1;
               resp_ack_d   = 1'b1;
               resp_adr_d   = adr_q;
               resp_dat_d   = we_q ? dat_q : dat_i;
               state_d      = S_CMD;
            end else if (wait_q == ACK_LAST) begin
               stb_d        = 1'b0;
               we_o_d       = 1'b0;
               wait_d       = 16'd0;
               resp_valid_d = 1'b1;
               resp_ack_d   = 1'b0;
               resp_adr_d   = adr_q;
               resp_dat_d   = 8'h00;
               state_d      = S_CMD;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end

         default: begin
            stb_d   = 1'b0;
            we_o_d  = 1'b0;
            wait_d  = 16'd0;
            idle_d  = 16'd0;
            state_d = S_CMD;
         end
      endcase

      busy_d = (state_d != S_CMD);
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_CMD;
         we_q         <= 1'b0;
         adr_q        <= 8'h00;
         dat_q        <= 8'h00;
         wait_q       <= 16'd0;
         idle_q       <= 16'd0;
         adr_o_q      <= 8'h00;
         dat_o_q      <= 8'h00;
         stb_q        <= 1'b0;
         we_o_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_ack_q   <= 1'b0;
         resp_adr_q   <= 8'h00;
         resp_dat_q   <= 8'h00;
         err_frame_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         wait_q       <= wait_d;
         idle_q       <= idle_d;
         adr_o_q      <= adr_o_d;
         dat_o_q      <= dat_o_d;
         stb_q        <= stb_d;
         we_o_q       <= we_o_d;
         resp_valid_q <= resp_valid_d;
         resp_ack_q   <= resp_ack_d;
         resp_adr_q   <= resp_adr_d;
         resp_dat_q   <= resp_dat_d;
         err_frame_q  <= err_frame_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign adr_o      = adr_o_q;
   assign dat_o      = dat_o_q;
   assign stb_o      = stb_q;
   assign we_o       = we_o_q;
   assign resp_valid = resp_valid_q;
   assign resp_ack   = resp_ack_q;
   assign resp_adr   = resp_adr_q;
   assign resp_dat   = resp_dat_q;
   assign err_frame  = err_frame_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: doc/write_ctl.md
Name: write_ctl

Overview:
- Bus-master counterpart to the read-snoop path.
- Consumes a byte stream from uart_rx (rx_data/rx_valid) and parses 3-byte command records {cmd, adr, dat}.
- Executes one bus cycle per record on the 8-bit stb/we/ack bus.
- Emits a one-cycle response record {ack, adr, dat}, formatted identically to read_ctl output, so it can feed the existing FIFO/UART TX path.

Parameters:
- ACK_TIMEOUT, 255: cycles stb_o is held without ack_i before the cycle is abandoned. Legal range 1..65535.
- BYTE_TIMEOUT, 65535: idle cycles allowed between bytes of one record before resync. Legal range 1..65535.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; single clock domain, synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- adr_o  out  8  bus address
- dat_o  out  8  bus write data
- stb_o  out  1  bus strobe
- we_o  out  1  bus write enable
- ack_i  in  1  bus acknowledge
- dat_i  in  8  bus read data
- resp_valid  out  1  one-cycle response strobe
- resp_ack  out  1  1 = acked, 0 = timed out
- resp_adr  out  8  address of completed cycle
- resp_dat  out  8  read data (read) / written data (write) / 0x00 (timeout)
- err_frame  out  1  one-cycle pulse on bad cmd byte or inter-byte timeout
- overrun  out  1  one-cycle pulse when a byte is dropped in S_BUS
- busy  out  1  high whenever state != S_CMD

Behaviour:
- Reset values: all outputs 0, state S_CMD, counters 0. Reset takes effect at the next clk_i edge from any state.
- Reset during S_BUS: stb_o drops at that edge and no resp_valid is produced.
- States: S_CMD, S_ADR, S_DAT, S_BUS.
- S_CMD, rx_valid with byte 0x00 (read) or 0x01 (write): latch we = bit0, go to S_ADR.
- S_CMD, any other byte: err_frame pulse next cycle, stay in S_CMD.
- S_ADR, rx_valid: latch adr, go to S_DAT.
- S_DAT, rx_valid: latch dat, go to S_BUS. dat is latched but ignored for reads.
- Entering S_BUS: stb_o=1, we_o=we, adr_o/dat_o driven in the cycle after the third byte's rx_valid (latency 1). All four stay stable until the cycle ends.
- Ack termination: ack_i sampled high at edge M with stb_o=1 means that at M+1:
  - stb_o=0 and we_o=0;
  - resp_valid=1, resp_ack=1, resp_adr=adr;
  - resp_dat = dat_i captured at M for a read, the latched dat for a write;
  - state returns to S_CMD.
- ack_i while stb_o=0 is ignored.
- Ack timeout: the wait counter counts cycles with stb_o=1. When it reaches ACK_TIMEOUT with no ack, stb_o is high for exactly ACK_TIMEOUT cycles. The next cycle has stb_o=0, resp_valid=1, resp_ack=0, resp_dat=0x00, state S_CMD.
- Ack and timeout in the same cycle: ack wins.
- resp_* outputs hold their values after the resp_valid pulse until the next response.
- Inter-byte timeout: in S_ADR/S_DAT, an idle counter increments each cycle without rx_valid and clears on rx_valid. At BYTE_TIMEOUT: err_frame pulse, partial record discarded, return to S_CMD.
- rx_valid in S_BUS: byte dropped, overrun pulse next cycle, no state change.
- rx_valid in the cycle resp_valid is asserted (state already S_CMD): byte is accepted normally.
- Back-to-back records: there are no dead cycles beyond the bus cycle itself.
- Counters are 16 bit, saturating logic not needed; each resets on state entry.

Test Plan:
- Write: bytes 01,3C,A5, slave acks 2 cycles after stb -> stb_o/we_o=1, adr_o=3C, dat_o=A5 for 3 cycles; then resp_valid with ack=1, adr=3C, dat=A5.
- Read: bytes 00,10,FF, slave returns dat_i=5A with ack -> we_o=0 throughout; resp_dat=5A, resp_adr=10, resp_ack=1.
- Timeout (ACK_TIMEOUT=8): bytes 01,20,77, no ack -> stb_o high exactly 8 cycles; resp_ack=0, resp_dat=00; a following read frame completes normally.
- Framing:
  - Byte 7F -> err_frame pulse, busy stays 0.
  - With BYTE_TIMEOUT=16: bytes 01,22 then silence -> err_frame 16 cycles after the 22 byte, no stb_o.
  - Then 00,22,00 -> normal read.
- Overrun: inject byte 55 while stb_o=1 -> overrun pulse, cycle completes unaffected, 55 not parsed as a cmd.
- Reset mid-bus: assert rst_i during stb_o=1 -> stb_o=0 and busy=0 next cycle, no resp_valid; a subsequent frame works.
